// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared encodings and helpers for the RV32 phase sequencer.
// State codes double as the 3-bit debug phase shown on the 7-seg display.
package cpu_phase_sequencer_pkg;

  localparam int SEQ_W            = 3;
  localparam int DEFAULT_DEBOUNCE = 1_000_000;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_FETCH     = 3'd1,
    SEQ_DECODE    = 3'd2,
    SEQ_EXEC      = 3'd3,
    SEQ_MEM       = 3'd4,
    SEQ_WB        = 3'd5,
    SEQ_HALT      = 3'd6,
    SEQ_STEP_WAIT = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic fetch;
    logic exec;
    logic mem;
    logic wb;
  } seq_strobe_t;

  function automatic seq_strobe_t decode_strobes(input seq_state_t s);
    seq_strobe_t stb;
    stb.fetch = (s == SEQ_FETCH);
    stb.exec  = (s == SEQ_EXEC);
    stb.mem   = (s == SEQ_MEM);
    stb.wb    = (s == SEQ_WB);
    return stb;
  endfunction

  function automatic logic is_wait_state(input seq_state_t s);
    return (s == SEQ_HALT) || (s == SEQ_STEP_WAIT);
  endfunction

endpackage

// File: rtl/cpu_phase_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge detect.
// btn_press is a single-cycle pulse per accepted press, however long the button is held.
module cpu_phase_sequencer_btn_debounce
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_press
);

  localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] stable_cnt;
  logic          level_p2;
  logic          level_p3;

  // synchronizer stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      level_p2   <= 1'b0;
      level_p3   <= 1'b0;
    end else begin
      level_p3 <= level_p2;
      if (sync_p1 == level_p2) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        stable_cnt <= '0;
        level_p2   <= sync_p1;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

  assign btn_press = level_p2 & ~level_p3;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Central FETCH->DECODE->EXEC->MEM->WB sequencer with ecall halt and button resume.
// Optional feature macro SINGLE_STEP_EN: honours step_mode and enables the STEP_WAIT state.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             ecall,
  input  logic             step_mode,
  output logic             fetch_stb,
  output logic             exec_stb,
  output logic             mem_stb,
  output logic             wb_stb,
  output logic             pc_en,
  output logic             halted,
  output logic [SEQ_W-1:0] phase,
  output logic [CNT_W-1:0] retired_cnt
);

  seq_state_t  state_q;
  seq_state_t  state_nx;
  seq_strobe_t stb_q;
  logic        halted_q;
  logic        ecall_q;
  logic        btn_press;
  logic        step_active;
  logic [CNT_W-1:0] retired_q;

  cpu_phase_sequencer_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .btn_press(btn_press)
  );

`ifdef SINGLE_STEP_EN
  assign step_active = step_mode;
`else
  logic unused_step_mode;
  assign unused_step_mode = step_mode;
  assign step_active      = 1'b0;
`endif

  // Next state; a button pulse outside HALT/STEP_WAIT falls through and is lost.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      SEQ_IDLE:   state_nx = SEQ_FETCH;
      SEQ_FETCH:  state_nx = SEQ_DECODE;
      SEQ_DECODE: state_nx = SEQ_EXEC;
      SEQ_EXEC:   state_nx = SEQ_MEM;
      SEQ_MEM:    state_nx = SEQ_WB;
      SEQ_WB: begin
        if (ecall_q)          state_nx = SEQ_HALT;
        else if (step_active) state_nx = SEQ_STEP_WAIT;
        else                  state_nx = SEQ_FETCH;
      end
      SEQ_HALT, SEQ_STEP_WAIT: begin
        if (btn_press) state_nx = SEQ_FETCH;
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

  // Strobes decoded from next state so each is a clean register output in its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      stb_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      stb_q    <= decode_strobes(state_nx);
      halted_q <= is_wait_state(state_nx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecall_q <= 1'b0;
    end else if (state_q == SEQ_EXEC) begin
      ecall_q <= ecall;
    end else if (state_q == SEQ_WB) begin
      ecall_q <= 1'b0;
    end
  end

  // Counter advances on the edge that completes WB; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (state_q == SEQ_WB) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign fetch_stb   = stb_q.fetch;
  assign exec_stb    = stb_q.exec;
  assign mem_stb     = stb_q.mem;
  assign wb_stb      = stb_q.wb;
  assign pc_en       = stb_q.wb;
  assign halted      = halted_q;
  assign phase       = state_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer: per-cycle behavioural model plus directed tests.
// A second instance with a 3-bit counter exercises counter wrap-around.
`timescale 1ns/1ps
module tb_cpu_phase_sequencer;

  localparam int N = 4;
  localparam int S_FETCH = 0, S_EXEC = 1, S_MEM = 2, S_WB = 3, S_HALT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic ecall = 1'b0;
  logic step_mode = 1'b0;

  logic fetch_stb, exec_stb, mem_stb, wb_stb, pc_en, halted;
  logic [2:0]  phase;
  logic [31:0] retired_cnt;
  logic w_fetch, w_exec, w_mem, w_wb, w_pc_en, w_halted;
  logic [2:0] w_phase;
  logic [2:0] w_cnt;

  int errors = 0;
  int checks = 0;

  cpu_phase_sequencer #(.DEBOUNCE_CYCLES(N), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .button(button), .ecall(ecall), .step_mode(step_mode),
    .fetch_stb(fetch_stb), .exec_stb(exec_stb), .mem_stb(mem_stb), .wb_stb(wb_stb),
    .pc_en(pc_en), .halted(halted), .phase(phase), .retired_cnt(retired_cnt)
  );

  cpu_phase_sequencer #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .button(button), .ecall(ecall), .step_mode(step_mode),
    .fetch_stb(w_fetch), .exec_stb(w_exec), .mem_stb(w_mem), .wb_stb(w_wb),
    .pc_en(w_pc_en), .halted(w_halted), .phase(w_phase), .retired_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic step_eff;
`ifdef SINGLE_STEP_EN
  assign step_eff = step_mode;
`else
  assign step_eff = 1'b0;
`endif

  bit m_idle, m_halt, m_stepw, m_ecq, m_lvl, m_lvl_d, m_press, m_diff;
  int m_pos;            // 0..4 = position within the five-phase instruction
  logic [31:0] m_cnt;
  bit bh [N+2];         // bh[0] = button sampled at this edge, bh[k] = k edges ago

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1; m_halt = 0; m_stepw = 0; m_ecq = 0; m_pos = 0; m_cnt = '0;
      m_lvl = 0; m_lvl_d = 0;
      for (int i = 0; i < N + 2; i++) bh[i] = 0;
    end else begin
      m_press = m_lvl && !m_lvl_d;
      if (m_idle) begin
        m_idle = 0; m_pos = 0;
      end else if (m_halt) begin
        if (m_press) begin m_halt = 0; m_stepw = 0; m_pos = 0; end
      end else if (m_pos == 4) begin
        m_cnt = m_cnt + 1;
        if (m_ecq) m_halt = 1;
        else if (step_eff) begin m_halt = 1; m_stepw = 1; end
        else m_pos = 0;
        m_ecq = 0;
      end else begin
        if (m_pos == 2) m_ecq = ecall;
        m_pos++;
      end
      // accepted level flips once N synchronized samples all disagree with it
      for (int i = N + 1; i > 0; i--) bh[i] = bh[i-1];
      bh[0] = button;
      m_diff = 1;
      for (int i = 2; i <= N + 1; i++) if (bh[i] == m_lvl) m_diff = 0;
      m_lvl_d = m_lvl;
      if (m_diff) m_lvl = !m_lvl;
    end
  end

  always @(posedge clk) begin
    bit run;
    logic [2:0] ep;
    logic [8:0] ev;
    #3;
    run = !m_idle && !m_halt;
    if (m_idle)      ep = 3'd0;
    else if (m_halt) ep = m_stepw ? 3'd7 : 3'd6;
    else             ep = 3'(m_pos + 1);
    ev = {run && m_pos == 0, run && m_pos == 2, run && m_pos == 3, run && m_pos == 4,
          run && m_pos == 4, m_halt, ep};
    check("outputs", {23'd0, fetch_stb, exec_stb, mem_stb, wb_stb, pc_en, halted, phase}, {23'd0, ev});
    check("retired_cnt", retired_cnt, m_cnt);
    check("wrap_inst", {20'd0, w_fetch, w_exec, w_mem, w_wb, w_pc_en, w_halted, w_phase, w_cnt},
          {20'd0, ev, m_cnt[2:0]});
  end

  // ---------------- directed stimulus ----------------
  function automatic logic sig_sel(input int which);
    case (which)
      S_FETCH: return fetch_stb;
      S_EXEC:  return exec_stb;
      S_MEM:   return mem_stb;
      S_WB:    return wb_stb;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int which, input int maxc, input string nm);
    bit hit = 0;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      if (sig_sel(which)) begin hit = 1; break; end
    end
    check({"wait_", nm}, {31'd0, hit}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; button = 0; ecall = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic raise_ecall();
    @(negedge clk); ecall = 1;
    @(negedge clk); ecall = 0;
  endtask

  initial begin
    int lat;
    bit seen;
    // T1: free-run after reset, period 5, wrap of 3-bit instance
    step_mode = 0;
    do_reset();
    #1;
    check("t1_idle_phase", {29'd0, phase}, 32'd0);
    check("t1_idle_fetch", {31'd0, fetch_stb}, 32'd0);
    check("t1_reset_cnt", retired_cnt, 32'd0);
    repeat (21) @(posedge clk); #1;
    check("t1_cnt_after_20", retired_cnt, 32'd4);
    check("t1_fetch_phase", {29'd0, phase}, 32'd1);
    repeat (15) @(posedge clk); #1;
    check("t1_wcnt_7", {29'd0, w_cnt}, 32'd7);
    repeat (5) @(posedge clk); #1;
    check("t1_cnt_8", retired_cnt, 32'd8);
    check("t1_wcnt_wrap", {29'd0, w_cnt}, 32'd0);

    // T2: ecall in EXEC of instruction 3
    do_reset();
    repeat (3) wait_for(S_EXEC, 20, "exec");
    raise_ecall();
    wait_for(S_WB, 10, "wb_ecall");
    check("t2_pc_en", {31'd0, pc_en}, 32'd1);
    @(posedge clk); #1;
    check("t2_halted", {31'd0, halted}, 32'd1);
    check("t2_phase_halt", {29'd0, phase}, 32'd6);
    check("t2_cnt", retired_cnt, 32'd3);
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (fetch_stb | exec_stb | mem_stb | wb_stb | pc_en) seen = 1;
    end
    check("t2_silent", {31'd0, seen}, 32'd0);

    // T3: clean press resumes with fixed latency; held button gives no second resume
    @(negedge clk); button = 1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!fetch_stb && lat < 20);
    check("t3_resume_latency", lat, 32'd7);
    wait_for(S_EXEC, 10, "t3_exec");
    raise_ecall();
    wait_for(S_HALT, 10, "t3_halt");
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (fetch_stb) seen = 1; end
    check("t3_held_no_resume", {31'd0, seen}, 32'd0);
    check("t3_cnt", retired_cnt, 32'd4);
    @(negedge clk); button = 0;
    repeat (10) @(negedge clk);

    // T4: bounce ignored; press landing on the WB->HALT transition ignored
    button = 1;
    repeat (2) @(negedge clk);
    button = 0;
    repeat (20) @(posedge clk); #1;
    check("t4_bounce_halted", {31'd0, halted}, 32'd1);
    @(negedge clk); button = 1;
    wait_for(S_FETCH, 20, "t4_resume");
    @(negedge clk); button = 0;
    repeat (12) @(posedge clk);
    wait_for(S_MEM, 10, "t4_mem");
    @(negedge clk); button = 1;
    wait_for(S_EXEC, 10, "t4_exec");
    raise_ecall();
    wait_for(S_HALT, 10, "t4_halt");
    repeat (20) @(posedge clk); #1;
    check("t4_entry_press_ignored", {31'd0, halted}, 32'd1);
    check("t4_cnt", retired_cnt, 32'd8);
    @(negedge clk); button = 0;
    repeat (8) @(negedge clk);

    // T5: single-step mode
    step_mode = 1;
    do_reset();
`ifdef SINGLE_STEP_EN
    wait_for(S_HALT, 20, "t5_step_wait");
    check("t5_phase_sw", {29'd0, phase}, 32'd7);
    check("t5_cnt1", retired_cnt, 32'd1);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); button = 1;
      wait_for(S_FETCH, 20, "t5_step_fetch");
      @(negedge clk); button = 0;
      wait_for(S_HALT, 20, "t5_step_halt");
      check("t5_cnt_step", retired_cnt, 32'(2 + p));
    end
`else
    repeat (21) @(posedge clk); #1;
    check("t5_free_run_cnt", retired_cnt, 32'd4);
    check("t5_free_run_halted", {31'd0, halted}, 32'd0);
`endif
    step_mode = 0;

    // T6: asynchronous reset during MEM
    do_reset();
    repeat (2) wait_for(S_MEM, 20, "t6_mem");
    check("t6_cnt_before", retired_cnt, 32'd1);
    #1 rst = 1;
    #1;
    check("t6_strobes_async", {27'd0, fetch_stb, exec_stb, mem_stb, wb_stb, pc_en}, 32'd0);
    check("t6_cnt_cleared", retired_cnt, 32'd0);
    check("t6_phase_idle", {29'd0, phase}, 32'd0);
    @(negedge clk); rst = 0;
    wait_for(S_WB, 20, "t6_wb");
    check("t6_cnt_wb", retired_cnt, 32'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
